// File: rtl/goofy_pkg.sv
// Shared codes, state encoding and code helpers for the mirrored one-hot
// sequence checker.
package goofy_pkg;

    localparam logic [7:0] CODE_P0 = 8'h81;
    localparam logic [7:0] CODE_P1 = 8'h42;
    localparam logic [7:0] CODE_P2 = 8'h24;
    localparam logic [7:0] CODE_P3 = 8'h18;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic is_legal_code(input logic [7:0] code);
        logic legal;
        case (code)
            CODE_P0, CODE_P1, CODE_P2, CODE_P3: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Illegal codes map to phase 0; callers qualify with is_legal_code.
    function automatic logic [1:0] code_to_phase(input logic [7:0] code);
        logic [1:0] ph;
        case (code)
            CODE_P1: ph = 2'd1;
            CODE_P2: ph = 2'd2;
            CODE_P3: ph = 2'd3;
            default: ph = 2'd0;
        endcase
        return ph;
    endfunction

    function automatic logic [7:0] next_code(input logic [7:0] code);
        logic [7:0] nxt;
        case (code)
            CODE_P0: nxt = CODE_P1;
            CODE_P1: nxt = CODE_P2;
            CODE_P2: nxt = CODE_P3;
            default: nxt = CODE_P0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/goofy_code_decoder.sv
// Combinational decode of a received counter code into legality, phase and
// the code that should follow it.
module goofy_code_decoder
    import goofy_pkg::*;
(
    input  logic [7:0] code_in,
    output logic       legal,
    output logic [1:0] phase,
    output logic [7:0] next_code_o
);

    always_comb begin
        legal       = is_legal_code(code_in);
        phase       = code_to_phase(code_in);
        next_code_o = next_code(code_in);
    end

endmodule

// File: rtl/goofy_sequence_checker.sv
// Lock/track checker for the 81-42-24-18 stream with flywheel on misses and
// a saturating error counter; all outputs registered.
//
// state     | meaning
// ST_HUNT   | waiting for any legal code to acquire the sequence
// ST_LOCKED | tracking expected code; MISS_LIMIT consecutive misses -> HUNT
module goofy_sequence_checker
    import goofy_pkg::*;
#(
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             code_valid,
    input  logic [7:0]       code_in,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [2:0]       MISS_LIM = 3'(MISS_LIMIT);
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       expected_q, expected_d;
    logic [2:0]       miss_q, miss_d;
    logic [1:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic       dec_legal;
    logic [1:0] dec_phase;
    logic [7:0] dec_next;
    logic [2:0] miss_inc;

    goofy_code_decoder u_decoder (
        .code_in     (code_in),
        .legal       (dec_legal),
        .phase       (dec_phase),
        .next_code_o (dec_next)
    );

    assign miss_inc = miss_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        miss_d        = miss_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        err_pulse_d   = 1'b0;
        err_count_d   = err_count_q;

        if (code_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (dec_legal) begin
                        state_d       = ST_LOCKED;
                        phase_d       = dec_phase;
                        phase_valid_d = 1'b1;
                        expected_d    = dec_next;
                        miss_d        = 3'd0;
                    end
                end
                ST_LOCKED: begin
                    if (code_in == expected_q) begin
                        phase_d       = dec_phase;
                        phase_valid_d = 1'b1;
                        expected_d    = dec_next;
                        miss_d        = 3'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_ONE;
                        end
                        // Resync on a legal code, otherwise flywheel past the lost sample.
                        if (dec_legal) begin
                            phase_d       = dec_phase;
                            phase_valid_d = 1'b1;
                            expected_d    = dec_next;
                        end else begin
                            expected_d    = next_code(expected_q);
                        end
                        if (miss_inc >= MISS_LIM) begin
                            state_d    = ST_HUNT;
                            miss_d     = 3'd0;
                            expected_d = CODE_P0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q       <= ST_HUNT;
            expected_q    <= CODE_P0;
            miss_q        <= 3'd0;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            miss_q        <= miss_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;

endmodule
